alu_scheduler: RTL and testbench
================================

# alu_scheduler

Shares one 64-bit Y86-64 ALU (add, subtract, and, xor) between two requesters: the execute stage (port 0) and an auxiliary address/flag unit (port 1). It arbitrates between simultaneous requests, computes the result and the condition codes ZF/SF/OF, and holds them in a one-entry output register under a valid/ready handshake. It sits between the requesters and the condition-code register in the SEQ/ALU area.

## Interface
Parameters:
- `WIDTH`, 64: operand and result width.

Ports:
- `clk`  input  1  rising-edge clock, the only clock.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `req_valid`  input  2  per-requester request valid; bit i belongs to requester i.
- `req_ready`  output  2  per-requester accept; a request is accepted when `req_valid[i] & req_ready[i]`.
- `req_op0`, `req_op1`  input  2  opcode: 00 add (A+B), 01 sub (A−B), 10 and, 11 xor.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  input  WIDTH  operands.
- `rsp_valid`  output  1  the output register holds a result.
- `rsp_ready`  input  1  the consumer takes the result.
- `rsp_id`  output  1  index of the requester that owns the result.
- `rsp_result`  output  WIDTH  result.
- `rsp_cc`  output  3  {ZF, SF, OF}.
- `busy`  output  1  same value as `rsp_valid`.

## Operation
- There are two states:
  - EMPTY: the output register is empty.
  - FULL: `rsp_valid` = 1.
- Slot is free when `~rsp_valid | rsp_ready`. `req_ready` is high on at most one bit, and only when the slot is free. The granted bit gets `req_ready`; `req_ready` is not conditioned on `req_valid` of the granted requester.
- Grant rule:
  - Only one requester valid: that requester wins.
  - Both valid: the requester named by the priority pointer `prio` wins.
- `prio` changes only after an accepted request while both requesters were valid; it then points to the loser. Reset value 0.
- On an accept, the result is computed combinationally from the winner's operands and registered. `rsp_id` = winner.
- Arithmetic is modulo 2^WIDTH.
- Flags:
  - ZF = (result == 0).
  - SF = result[WIDTH-1].
  - OF for add = (a[MSB] == b[MSB]) & (r[MSB] != a[MSB]).
  - OF for sub = (a[MSB] != b[MSB]) & (r[MSB] != a[MSB]).
  - OF for and/xor = 0.
- Transitions:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on `rsp_ready` with no accept.
  - FULL → FULL on `rsp_ready` with a simultaneous accept: the register is overwritten with the new result.
  - FULL with `rsp_ready` = 0: the output is held stable and `req_ready` = 0.
- Reset, including mid-operation: a pending result is discarded, not delivered. Reset values:
  - `rsp_valid` = 0, `busy` = 0, `req_ready` = 00.
  - `rsp_id` = 0, `rsp_result` = 0, `rsp_cc` = 000.
  - `prio` = 0.

## Timing
- Latency is 1 cycle: a request accepted at edge N gives `rsp_valid` = 1 with the result after edge N.
- Throughput is 1 result per cycle while `rsp_ready` is held high.
- `req_ready` is combinational from `rsp_valid`, `rsp_ready`, `req_valid` and `prio`. There is no combinational path from operands to outputs.
- A requester must hold its op and operands stable while `req_valid` is high and it is not yet accepted.
- Asynchronous assertion of `rst_n` clears all registers immediately. Deassertion is synchronised externally.

## Configuration
- `ALU_SCHED_RR_EN` defined: round-robin arbitration using `prio`, as described above.
- `ALU_SCHED_RR_EN` undefined: fixed priority, requester 0 always wins a tie. The `prio` register is removed. Requester 1 can starve while requester 0 requests every cycle; this is accepted for that build.

## Test plan
- Only requester 0 valid, sub, A = −2, B = 1, `rsp_ready` = 1 → the next cycle shows `rsp_result` = 0xFFFF_FFFF_FFFF_FFFD, cc = {0,1,0}, `rsp_id` = 0.
- Sub, A = 1, B = 0x8000_0000_0000_0000 → result = 0x8000_0000_0000_0001, cc = {0,1,1}. Add, A = B = 0x7FFF_FFFF_FFFF_FFFF → result = 0xFFFF_FFFF_FFFF_FFFE, OF = 1. Xor, A = B = 10000 → result = 0, cc = {1,0,0}.
- Both requesters valid for 4 cycles, `rsp_ready` = 1:
  - With RR: `rsp_id` sequence 0, 1, 0, 1.
  - Without RR: 0, 0, 0, 0, with `req_ready[1]` never asserted.
- `rsp_ready` = 0 for 3 cycles while FULL → `rsp_result`, `rsp_cc` and `rsp_id` are stable and `req_ready` = 00. Then `rsp_ready` = 1 with a pending request → the register is replaced in that same cycle with no bubble.
- `rst_n` pulsed low mid-cycle while FULL → all outputs go to 0 immediately, without waiting for a clock edge. The first grant after reset goes to requester 0 on a tie.

Source files
------------

// File: rtl/alu_scheduler.sv
// Shared Y86-64 ALU (add/sub/and/xor) for two requesters with a one-entry result register.
// Define ALU_SCHED_RR_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module alu_scheduler #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       rsp_cc,
  output logic             busy
);

  typedef enum logic {EMPTY, FULL} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_XOR = 2'b11} op_t;

  state_t           state_q, state_d;
  logic             win;
  logic             slot_free;
  logic             accept;
  op_t              op;
  logic [WIDTH-1:0] a, b, res;
  logic             of;

`ifdef ALU_SCHED_RR_EN
  logic prio_q;
`endif

  // Winner on a tie comes from prio (round-robin) or is always requester 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    win = 1'b0;
    if (req_valid == 2'b10) begin
      win = 1'b1;
    end else if (req_valid == 2'b11) begin
`ifdef ALU_SCHED_RR_EN
      win = prio_q;
`else
      win = 1'b0;
`endif
    end
  end

  assign slot_free = ~rsp_valid | rsp_ready;
  assign req_ready = (rst_n & slot_free) ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    op  = op_t'(win ? req_op1 : req_op0);
    a   = win ? req_a1 : req_a0;
    b   = win ? req_b1 : req_b0;
    res = '0;
    of  = 1'b0;
    unique case (op)
      OP_ADD: begin
        res = a + b;
        of  = (a[WIDTH-1] == b[WIDTH-1]) & (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res = a - b;
        of  = (a[WIDTH-1] != b[WIDTH-1]) & (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_XOR: res = a ^ b;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (rsp_ready && !accept) state_d = EMPTY;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_cc     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_id     <= win;
        rsp_result <= res;
        rsp_cc     <= {(res == '0), res[WIDTH-1], of};
      end
    end
  end

`ifdef ALU_SCHED_RR_EN
  // prio moves only when a tie was actually resolved; it then names the loser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        prio_q <= 1'b0;
    else if (accept && &req_valid)     prio_q <= ~win;
  end
`endif

  assign rsp_valid = (state_q == FULL);
  assign busy      = rsp_valid;

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a signed-arithmetic reference model.
module tb_alu_scheduler;

`ifdef ALU_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk, rst_n;
  logic [1:0]  req_valid, req_ready, req_op0, req_op1;
  logic [63:0] req_a0, req_b0, req_a1, req_b1;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [63:0] rsp_result;
  logic [2:0]  rsp_cc;

  int checks = 0;
  int errors = 0;

  alu_scheduler #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_cc(rsp_cc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference ALU: overflow taken from a 65-bit signed sum leaving the 64-bit range.
  function automatic void ref_alu(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic [2:0] cc);
    logic [64:0] wide;
    logic        of;
    of   = 1'b0;
    wide = '0;
    case (op)
      2'd0: begin wide = {a[63], a} + {b[63], b}; r = wide[63:0]; of = wide[64] != wide[63]; end
      2'd1: begin wide = {a[63], a} - {b[63], b}; r = wide[63:0]; of = wide[64] != wide[63]; end
      2'd2: r = a & b;
      default: r = a ^ b;
    endcase
    cc = {(r == 64'd0), r[63], of};
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a, b, res;
    logic [2:0]  cc;
  } vec_t;

  vec_t vecs[6];

  logic        pend[2];
  logic [1:0]  pop[2];
  logic [63:0] pa[2], pb[2];
  logic        m_full, m_id, m_prio;
  logic [63:0] m_res;
  logic [2:0]  m_cc;

  function automatic logic [63:0] rand_operand();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'h8000_0000_0000_0000;
      1: v = 64'h7FFF_FFFF_FFFF_FFFF;
      2: v = 64'hFFFF_FFFF_FFFF_FFFF;
      3: v = 64'd0;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    vecs[0] = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFD, 3'b010};
    vecs[1] = '{2'd1, 64'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 3'b011};
    vecs[2] = '{2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 3'b011};
    vecs[3] = '{2'd3, 64'd10000, 64'd10000, 64'd0, 3'b100};
    vecs[4] = '{2'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 64'd0, 3'b100};
    vecs[5] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 3'b100};

    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    req_op0 = 2'd0; req_op1 = 2'd0;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_ready", req_ready, 2'b00);
    check("reset_result", rsp_result, 0);
    check("reset_cc", rsp_cc, 0);
    rst_n = 1'b1;

    // Directed vectors through requester 0.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid = 2'b01; rsp_ready = 1'b1;
      req_op0 = vecs[i].op; req_a0 = vecs[i].a; req_b0 = vecs[i].b;
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      check($sformatf("vec%0d_valid", i), rsp_valid, 1);
      check($sformatf("vec%0d_result", i), rsp_result, vecs[i].res);
      check($sformatf("vec%0d_cc", i), rsp_cc, vecs[i].cc);
      check($sformatf("vec%0d_id", i), rsp_id, 0);
    end

    // Tie for four cycles with the consumer always ready.
    @(negedge clk);
    req_valid = 2'b11; rsp_ready = 1'b1;
    req_op0 = 2'd0; req_a0 = 64'd1; req_b0 = 64'd2;
    req_op1 = 2'd3; req_a1 = 64'd8; req_b1 = 64'd1;
    for (int i = 0; i < 4; i++) begin
      logic exp_id;
      exp_id = RR ? 1'(i % 2) : 1'b0;
      #1;
      check($sformatf("tie%0d_ready", i), req_ready, exp_id ? 2'b10 : 2'b01);
      @(negedge clk);
      #1;
      check($sformatf("tie%0d_id", i), rsp_id, exp_id);
      check($sformatf("tie%0d_result", i), rsp_result, exp_id ? 64'd9 : 64'd3);
    end
    req_valid = 2'b00;
    @(negedge clk);

    // Hold while the consumer stalls, then replace without a bubble.
    req_valid = 2'b01; rsp_ready = 1'b0;
    req_op0 = 2'd0; req_a0 = 64'd5; req_b0 = 64'd6;
    @(negedge clk);
    req_valid = 2'b10;
    req_op1 = 2'd1; req_a1 = 64'd100; req_b1 = 64'd1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check($sformatf("hold%0d_valid", i), rsp_valid, 1);
      check($sformatf("hold%0d_result", i), rsp_result, 64'd11);
      check($sformatf("hold%0d_id", i), rsp_id, 0);
      check($sformatf("hold%0d_cc", i), rsp_cc, 3'b000);
      check($sformatf("hold%0d_ready", i), req_ready, 2'b00);
    end
    rsp_ready = 1'b1;
    #1;
    check("replace_ready", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("replace_valid", rsp_valid, 1);
    check("replace_result", rsp_result, 64'd99);
    check("replace_id", rsp_id, 1);
    @(negedge clk);

    // Asynchronous reset while FULL; tie afterwards must go to requester 0.
    req_valid = 2'b11; rsp_ready = 1'b0;
    req_op0 = 2'd0; req_a0 = 64'd1; req_b0 = 64'd1;
    req_op1 = 2'd0; req_a1 = 64'd7; req_b1 = 64'd7;
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("prerst_valid", rsp_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", rsp_result, 0);
    check("rst_cc", rsp_cc, 0);
    check("rst_id", rsp_id, 0);
    check("rst_ready", req_ready, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b11; rsp_ready = 1'b1;
    #1;
    check("postrst_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("postrst_id", rsp_id, 0);
    check("postrst_result", rsp_result, 64'd2);
    @(negedge clk);

    // Randomized traffic against the reference model.
    m_full = 1'b0; m_id = 1'b0; m_res = '0; m_cc = '0;
    m_prio = RR;  // the post-reset tie left requester 1 as the loser
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic       free, any, win, both;
      logic [63:0] r;
      logic [2:0]  cc;
      @(negedge clk);
      #1;
      check("rnd_valid", rsp_valid, m_full);
      check("rnd_busy", busy, m_full);
      if (m_full) begin
        check("rnd_result", rsp_result, m_res);
        check("rnd_cc", rsp_cc, m_cc);
        check("rnd_id", rsp_id, m_id);
      end
      for (int q = 0; q < 2; q++) begin
        if (!pend[q] && $urandom_range(0, 1) == 1) begin
          pend[q] = 1'b1;
          pop[q]  = 2'($urandom_range(0, 3));
          pa[q]   = rand_operand();
          pb[q]   = rand_operand();
        end
      end
      req_valid = {pend[1], pend[0]};
      req_op0 = pop[0]; req_a0 = pa[0]; req_b0 = pb[0];
      req_op1 = pop[1]; req_a1 = pa[1]; req_b1 = pb[1];
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      free = !m_full || rsp_ready;
      any  = pend[0] || pend[1];
      both = pend[0] && pend[1];
      win  = both ? (RR ? m_prio : 1'b0) : pend[1];
      if (!free)
        check("rnd_ready_stall", req_ready, 2'b00);
      else if (any)
        check("rnd_ready_grant", req_ready, win ? 2'b10 : 2'b01);
      if (free && any) begin
        ref_alu(pop[win], pa[win], pb[win], r, cc);
        m_full = 1'b1; m_id = win; m_res = r; m_cc = cc;
        if (both && RR) m_prio = ~win;
        pend[win] = 1'b0;
      end else if (rsp_ready) begin
        m_full = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
